// File: rtl/cmd_mem_reader_if.sv
// Bundles the command-memory read port, the clear handshake towards the
// writer and the command handshake towards the impulse generator.
interface cmd_mem_reader_if #(
  parameter int ADDR_W = 8
);
  // memory read port
  logic [ADDR_W-1:0] rdaddress;
  logic              rden;
  logic [337:0]      q;
  // clear handshake with the writer
  logic              CLR_REQ;
  logic [ADDR_W-1:0] CLR_ADDR;
  logic              CLR_ACK;
  // command handshake with the impulse generator
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_LATE;
  logic [47:0]       FREQ;
  logic [47:0]       FREQ_STEP;
  logic [31:0]       FREQ_RATE;
  logic [63:0]       TIME_START;
  logic [15:0]       N_impulse;
  logic [1:0]        TYPE_impulse;
  logic [31:0]       Interval_Ti;
  logic [31:0]       Interval_Tp;
  logic [31:0]       Tblank1;
  logic [31:0]       Tblank2;

  modport master (
    output rdaddress, rden, CLR_REQ, CLR_ADDR, CMD_VALID, CMD_LATE,
           FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    input  q, CLR_ACK, CMD_READY
  );

  modport slave (
    input  rdaddress, rden, CLR_REQ, CLR_ADDR, CMD_VALID, CMD_LATE,
           FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
           Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    output q, CLR_ACK, CMD_READY
  );
endinterface

// File: rtl/cmd_mem_reader.sv
// Read side of the command register memory: scans every row for the pending
// command with the earliest TIME_START, waits for system time to reach it,
// hands it to the impulse generator and then asks the writer to clear it.
module cmd_mem_reader #(
  parameter int N_IDX    = 256,
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 2,
  parameter int LATE_TOL = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [63:0]      TIME_NOW,
  input  logic             MEM_UPD,
  cmd_mem_reader_if.master bus
);
  localparam int          ROW_W    = 338;
  localparam int          SCAN_LEN = N_IDX + RD_LAT;
  localparam int          CNT_MIN  = $clog2(SCAN_LEN + 1);
  localparam int          CNT_W    = (CNT_MIN > ADDR_W) ? CNT_MIN : ADDR_W + 1;
  localparam logic [63:0] TS_EMPTY = '1;

  typedef enum logic [2:0] {IDLE, SCAN, WAIT_TIME, OUT, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              scan_start;
  logic              scan_last;
  logic              rescan;
  logic              rd_act;
  logic [RD_LAT-1:0] vld_p;
  logic [ADDR_W-1:0] addr_p [RD_LAT];
  logic              cand_vld;
  logic [ADDR_W-1:0] cand_addr;
  logic [ROW_W-1:0]  cand_row;
  logic [63:0]       cand_ts;
  logic [63:0]       q_ts;
  logic              take;
  logic              found;
  logic              late;

  // Elapsed time past the start tick; only evaluated once now >= start.
  function automatic logic is_late(input logic [63:0] now, input logic [63:0] start);
    logic [63:0] elapsed;
    elapsed = now - start;
    return elapsed > 64'(LATE_TOL);
  endfunction

  assign rd_act    = (state == SCAN) && (cnt < CNT_W'(N_IDX));
  assign scan_last = (state == SCAN) && (cnt == CNT_W'(SCAN_LEN - 1));
  assign q_ts      = bus.q[337:274];
  assign cand_ts   = cand_row[337:274];

  // A returning row replaces the candidate only when strictly earlier, so the
  // lower address wins a tie because it is seen first.
  assign take  = (state == SCAN) && vld_p[RD_LAT-1] && (q_ts != TS_EMPTY) &&
                 (!cand_vld || (q_ts < cand_ts));
  assign found = cand_vld || take;

  // Next-state decode; scan_start marks every (re)entry into a fresh scan.
  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    case (state)
      IDLE: begin
        if (EN) begin
          state_nxt  = SCAN;
          scan_start = 1'b1;
        end
      end
      SCAN: begin
        if (!EN) begin
          state_nxt = IDLE;
        end else if (scan_last) begin
          if (rescan || MEM_UPD || !found) scan_start = 1'b1;
          else                             state_nxt  = WAIT_TIME;
        end
      end
      WAIT_TIME: begin
        if (!EN) begin
          state_nxt = IDLE;
        end else if (MEM_UPD) begin
          state_nxt  = SCAN;
          scan_start = 1'b1;
        end else if (TIME_NOW >= cand_ts) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.CMD_READY) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (bus.CLR_ACK) begin
          if (EN) begin
            state_nxt  = SCAN;
            scan_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, scan counter, rescan flag, read-valid pipeline, late flag.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rescan   <= 1'b0;
      vld_p    <= '0;
      cand_vld <= 1'b0;
      late     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (scan_start) begin
        cnt      <= '0;
        rescan   <= 1'b0;
        vld_p    <= '0;
        cand_vld <= 1'b0;
      end else begin
        if (state == SCAN) cnt <= cnt + 1'b1;
        if ((state == SCAN) && MEM_UPD) rescan <= 1'b1;
        if (take) cand_vld <= 1'b1;
        vld_p[0] <= rd_act;
        for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      end
      if ((state == WAIT_TIME) && (state_nxt == OUT)) late <= is_late(TIME_NOW, cand_ts);
    end
  end

  // ---- stage boundary: read address travels alongside the memory latency ----
  // Address pipeline matching the memory read latency.
  always_ff @(posedge CLK) begin
    addr_p[0] <= bus.rdaddress;
    for (int i = 1; i < RD_LAT; i++) addr_p[i] <= addr_p[i-1];
  end

  // ---- stage boundary: compare result latched into the candidate ----
  // Candidate row and address; cleared by reset so the command fields read 0.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cand_row  <= '0;
      cand_addr <= '0;
    end else if (take) begin
      cand_row  <= bus.q;
      cand_addr <= addr_p[RD_LAT-1];
    end
  end

  assign bus.rden      = rd_act;
  assign bus.rdaddress = rd_act ? cnt[ADDR_W-1:0] : '0;
  assign bus.CMD_VALID = (state == OUT);
  assign bus.CMD_LATE  = (state == OUT) && late;
  assign bus.CLR_REQ   = (state == CLEAR);
  assign bus.CLR_ADDR  = (state == CLEAR) ? cand_addr : '0;

  assign bus.TIME_START   = cand_row[337:274];
  assign bus.FREQ         = cand_row[273:226];
  assign bus.FREQ_STEP    = cand_row[225:178];
  assign bus.FREQ_RATE    = cand_row[177:146];
  assign bus.N_impulse    = cand_row[145:130];
  assign bus.TYPE_impulse = cand_row[129:128];
  assign bus.Interval_Ti  = cand_row[127:96];
  assign bus.Interval_Tp  = cand_row[95:64];
  assign bus.Tblank1      = cand_row[63:32];
  assign bus.Tblank2      = cand_row[31:0];
endmodule

// File: tb/tb_cmd_mem_reader.sv
// Bench for cmd_mem_reader: behavioural memory and writer, a scoreboard that
// predicts issue order by sorting pending rows on (TIME_START, address).
module tb_cmd_mem_reader;
  localparam int          N_IDX    = 256;
  localparam int          ADDR_W   = 8;
  localparam int          RD_LAT   = 2;
  localparam int          LATE_TOL = 16;
  localparam logic [63:0] EMPTY    = '1;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        EN = 1'b0;
  logic        MEM_UPD = 1'b0;
  logic [63:0] TIME_NOW = '0;

  cmd_mem_reader_if #(.ADDR_W(ADDR_W)) bus ();

  cmd_mem_reader #(.N_IDX(N_IDX), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .LATE_TOL(LATE_TOL)) dut (
    .CLK(CLK), .rst_n(rst_n), .EN(EN), .TIME_NOW(TIME_NOW), .MEM_UPD(MEM_UPD), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Memory with two-cycle read latency.
  logic [337:0] mem [N_IDX];
  logic [337:0] rd_s1;
  always @(posedge CLK) begin
    rd_s1 <= mem[bus.rdaddress];
    bus.q <= rd_s1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [337:0] got, input logic [337:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus / writer / scoreboard state
  int          rdy_mode = 1;   // 0 hold low, 1 high, 2 random
  int          tn_step = 1;
  bit          tn_rand = 0;
  bit          auto_ack = 1;
  bit          acked = 0;
  int          ack_dly = 0;
  logic [63:0] tn_prev = '0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [337:0] cur_row = '0;
  logic [ADDR_W-1:0] cur_addr = '0;
  bit          in_cmd = 0;
  logic [63:0] rise_tn = '0;
  logic        rise_late = 1'b0;
  int          n_issued = 0;
  int          n_cleared = 0;
  // sampled outputs
  logic        rden_s = 0, valid_s = 0, clr_s = 0, clr_prev = 0;
  logic [ADDR_W-1:0] raddr_s = '0, clr_addr_s = '0;
  logic [337:0] fields_s;

  function automatic logic [337:0] out_fields();
    return {bus.TIME_START, bus.FREQ, bus.FREQ_STEP, bus.FREQ_RATE, bus.N_impulse,
            bus.TYPE_impulse, bus.Interval_Ti, bus.Interval_Tp, bus.Tblank1, bus.Tblank2};
  endfunction

  function automatic logic [337:0] make_row(input logic [63:0] ts);
    logic [337:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r = {r[305:0], 32'($urandom)};
    r[337:274] = ts;
    return r;
  endfunction

  // One clock: drive inputs just after the edge, sample and score at the falling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    tn_prev  = TIME_NOW;
    TIME_NOW = TIME_NOW + 64'(tn_rand ? $urandom_range(0, 2) : tn_step);
    MEM_UPD  = 1'b0;
    bus.CLR_ACK = 1'b0;
    if (clr_s && !acked && auto_ack) begin
      if (ack_dly == 0) begin
        mem[clr_addr_s] = {EMPTY, 274'(0)};
        bus.CLR_ACK = 1'b1;
        acked = 1;
        ack_dly = $urandom_range(0, 3);
      end else begin
        ack_dly--;
      end
    end
    if (!clr_s) acked = 0;
    case (rdy_mode)
      0:       bus.CMD_READY = 1'b0;
      1:       bus.CMD_READY = 1'b1;
      default: bus.CMD_READY = 1'($urandom_range(0, 1));
    endcase
    @(negedge CLK);
    rden_s     = bus.rden;
    raddr_s    = bus.rdaddress;
    valid_s    = bus.CMD_VALID;
    clr_prev   = clr_s;
    clr_s      = bus.CLR_REQ;
    clr_addr_s = bus.CLR_ADDR;
    fields_s   = out_fields();
    if (valid_s) begin
      if (!in_cmd) begin
        in_cmd = 1;
        rise_tn = tn_prev;
        rise_late = bus.CMD_LATE;
        n_issued++;
        chk("cmd_expected", 1'(exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          cur_addr = exp_q.pop_front();
          cur_row  = mem[cur_addr];
        end
        chk("not_early", 1'(rise_tn >= cur_row[337:274]), 1'b1);
      end
      chk("fields", fields_s, cur_row);
      chk("late_flag", bus.CMD_LATE, 1'((rise_tn - cur_row[337:274]) > 64'(LATE_TOL)));
    end else begin
      in_cmd = 0;
    end
    if (clr_s && !clr_prev) begin
      chk("clr_addr", clr_addr_s, cur_addr);
      chk("clr_follows_cmd", 1'(n_issued == n_cleared + 1), 1'b1);
      n_cleared++;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N_IDX; i++) mem[i] = {EMPTY, 274'(0)};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.CMD_VALID, 1'b0);
    chk({tag, "_late"},  bus.CMD_LATE, 1'b0);
    chk({tag, "_clrreq"}, bus.CLR_REQ, 1'b0);
    chk({tag, "_clraddr"}, bus.CLR_ADDR, '0);
    chk({tag, "_rden"}, bus.rden, 1'b0);
    chk({tag, "_fields"}, out_fields(), '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    EN = 1'b0;
    MEM_UPD = 1'b0;
    bus.CLR_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    exp_q.delete();
    in_cmd = 0; acked = 0; clr_s = 0; clr_prev = 0; valid_s = 0;
    n_cleared = n_issued;
    tn_rand = 0; tn_step = 1; auto_ack = 1;
  endtask

  task automatic wait_rise(input int budget, input string tag);
    int start;
    start = n_issued;
    for (int i = 0; i < budget && n_issued == start; i++) tick();
    chk(tag, 1'(n_issued != start), 1'b1);
  endtask

  task automatic drain(input int budget, input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = (exp_q.size() == 0) && !in_cmd && !clr_s && (n_cleared == n_issued);
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int errs;
    int base;
    logic [ADDR_W-1:0] ra [12];
    logic [63:0]       rt [12];
    bit                used [12];
    bit                dup;

    bus.CMD_READY = 1'b0;
    bus.CLR_ACK = 1'b0;
    clear_mem();
    @(negedge CLK);
    check_reset_outputs("reset");

    // all rows empty: continuous scanning, nothing issued
    do_reset();
    EN = 1'b1;
    for (int i = 0; i < 5 && !rden_s; i++) tick();
    chk("scan_start_addr", {rden_s, raddr_s}, {1'b1, ADDR_W'(0)});
    errs = 0;
    for (int k = 1; k <= N_IDX + RD_LAT; k++) begin
      tick();
      if (rden_s !== ((k < N_IDX) || (k == N_IDX + RD_LAT))) errs++;
      if (rden_s && (raddr_s !== ((k < N_IDX) ? ADDR_W'(k) : ADDR_W'(0)))) errs++;
    end
    chk("scan_sequence", errs, 0);
    repeat (600) tick();
    chk("empty_no_cmd", n_issued, 0);
    chk("empty_no_clr", n_cleared, 0);

    // row 7 at t=1000, consumer stalls 10 cycles
    do_reset();
    clear_mem();
    mem[7] = make_row(64'd1000);
    TIME_NOW = '0;
    rdy_mode = 0;
    exp_q.push_back(ADDR_W'(7));
    EN = 1'b1;
    wait_rise(2000, "r7_issued");
    chk("r7_latency", rise_tn, 64'd1000);
    chk("r7_late", rise_late, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", valid_s, 1'b1);
    end
    rdy_mode = 1;
    drain(600, "r7_drain");

    // tie on TIME_START: lower address first
    do_reset();
    clear_mem();
    mem[5] = make_row(64'd500);
    mem[3] = make_row(64'd500);
    TIME_NOW = '0;
    rdy_mode = 2;
    exp_q.push_back(ADDR_W'(3));
    exp_q.push_back(ADDR_W'(5));
    EN = 1'b1;
    drain(3000, "tie_drain");

    // earlier row written while waiting on a later one
    do_reset();
    clear_mem();
    mem[9] = make_row(64'd2000);
    TIME_NOW = '0;
    rdy_mode = 1;
    exp_q.push_back(ADDR_W'(2));
    exp_q.push_back(ADDR_W'(9));
    EN = 1'b1;
    for (int i = 0; i < 1000 && TIME_NOW < 64'd600; i++) tick();
    chk("wait_rden_low", rden_s, 1'b0);
    mem[2] = make_row(64'd1500);
    MEM_UPD = 1'b1;
    wait_rise(2000, "r2_issued");
    chk("r2_time", rise_tn, 64'd1500);
    wait_rise(2000, "r9_issued");
    chk("r9_time", rise_tn, 64'd2000);
    drain(600, "upd_drain");

    // late command, then reset while the clear is outstanding
    do_reset();
    clear_mem();
    mem[4] = make_row(64'd100);
    TIME_NOW = 64'd200;
    tn_step = 0;
    auto_ack = 0;
    rdy_mode = 1;
    exp_q.push_back(ADDR_W'(4));
    EN = 1'b1;
    for (int i = 0; i < 1000 && !clr_s; i++) tick();
    chk("late_clr_seen", clr_s, 1'b1);
    chk("late_set", rise_late, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_clear");
    base = n_issued;
    do_reset();
    tn_step = 0;
    exp_q.push_back(ADDR_W'(4));
    EN = 1'b1;
    drain(1500, "reissue_drain");
    chk("reissue_count", n_issued, base + 1);

    // randomized rows, random consumer back-pressure and writer ack delays
    do_reset();
    clear_mem();
    for (int i = 0; i < 12; i++) begin
      do begin
        ra[i] = ADDR_W'($urandom_range(0, N_IDX - 1));
        dup = 0;
        for (int j = 0; j < i; j++) if (ra[j] == ra[i]) dup = 1;
      end while (dup);
      rt[i] = 64'(300 + 40 * $urandom_range(0, 50));
      mem[ra[i]] = make_row(rt[i]);
      used[i] = 0;
    end
    for (int n = 0; n < 12; n++) begin
      int best;
      best = -1;
      for (int i = 0; i < 12; i++)
        if (!used[i] && (best < 0 || rt[i] < rt[best] || (rt[i] == rt[best] && ra[i] < ra[best])))
          best = i;
      used[best] = 1;
      exp_q.push_back(ra[best]);
    end
    TIME_NOW = '0;
    tn_rand = 1;
    rdy_mode = 2;
    base = n_issued;
    EN = 1'b1;
    drain(40000, "rand_drain");
    chk("rand_count", n_issued - base, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
